// File: rtl/capture_ctrl.sv
// Acquisition sequencer for the circular sample RAM: pre-fill, arm,
// wait for trigger, write the post-trigger tail, then hold done.
module capture_ctrl #(
    parameter int ADDR_W = 9
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              run,
    input  logic              stop,
    input  logic              clr_cap_done,
    input  logic [ADDR_W-1:0] trig_pos,
    input  logic              en,
    input  logic              triggered,
    output logic              we,
    output logic [ADDR_W-1:0] waddr,
    output logic              armed,
    output logic              capture_done,
    output logic [ADDR_W-1:0] trig_addr,
    output logic              busy
);

    typedef enum logic [2:0] {
        IDLE,
        PRE,
        ARMED,
        POST,
        DONE
    } state_t;

    localparam logic [ADDR_W:0] DEPTH_V = (ADDR_W+1)'(1) << ADDR_W;

    state_t            state;
    logic [ADDR_W:0]   cnt;
    logic [ADDR_W:0]   cnt_inc;
    logic [ADDR_W:0]   pre;
    logic [ADDR_W:0]   tp_ext;
    logic [ADDR_W-1:0] tp;

    // busy is a registered mirror of PRE/ARMED/POST; the reset edge never writes
    assign we      = en & busy & ~rst;
    assign cnt_inc = cnt + 1'b1;
    assign tp_ext  = {1'b0, tp};
    assign pre     = DEPTH_V - tp_ext;

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            waddr        <= '0;
            trig_addr    <= '0;
            cnt          <= '0;
            tp           <= '0;
            armed        <= 1'b0;
            capture_done <= 1'b0;
            busy         <= 1'b0;
        end else if (stop) begin
            state        <= IDLE;
            armed        <= 1'b0;
            capture_done <= 1'b0;
            busy         <= 1'b0;
        end else begin
            if (we) begin
                waddr <= waddr + 1'b1;
            end
            unique case (state)
                IDLE: begin
                    if (run) begin
                        state <= PRE;
                        busy  <= 1'b1;
                        waddr <= '0;
                        cnt   <= '0;
                        tp    <= (trig_pos == '0) ? ADDR_W'(1) : trig_pos;
                    end
                end
                PRE: begin
                    if (en) begin
                        cnt <= cnt_inc;
                        if (cnt_inc == pre) begin
                            state <= ARMED;
                            armed <= 1'b1;
                        end
                    end
                end
                ARMED: begin
                    if (triggered) begin
                        // a write in the trigger cycle is post-sample #1
                        trig_addr <= waddr;
                        armed     <= 1'b0;
                        cnt       <= en ? (ADDR_W+1)'(1) : '0;
                        if (en && tp == ADDR_W'(1)) begin
                            state        <= DONE;
                            busy         <= 1'b0;
                            capture_done <= 1'b1;
                        end else begin
                            state <= POST;
                        end
                    end
                end
                POST: begin
                    if (en) begin
                        cnt <= cnt_inc;
                        if (cnt_inc == tp_ext) begin
                            state        <= DONE;
                            busy         <= 1'b0;
                            capture_done <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    if (clr_cap_done) begin
                        state        <= IDLE;
                        capture_done <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    armed <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_capture_ctrl.sv
// Scenario bench for capture_ctrl at ADDR_W=4 with a write-address
// scoreboard fed by each scenario and drained by a write monitor.
module tb_capture_ctrl;

    localparam int AW = 4;

    logic          clk = 1'b0;
    logic          rst, run, stop, clr_cap_done, en, triggered;
    logic [AW-1:0] trig_pos;
    logic          we, armed, capture_done, busy;
    logic [AW-1:0] waddr, trig_addr;

    int            checks = 0;
    int            errors = 0;
    logic [AW-1:0] exp_q[$];
    logic [AW-1:0] mon_e;

    capture_ctrl #(.ADDR_W(AW)) dut (
        .clk(clk), .rst(rst), .run(run), .stop(stop),
        .clr_cap_done(clr_cap_done), .trig_pos(trig_pos),
        .en(en), .triggered(triggered), .we(we), .waddr(waddr),
        .armed(armed), .capture_done(capture_done),
        .trig_addr(trig_addr), .busy(busy)
    );

    always #5 clk = ~clk;

    // every RAM write must match the next expected address
    always @(negedge clk) begin
        if (we === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL write_unexpected waddr=%0d expected no write", waddr);
            end else begin
                mon_e = exp_q.pop_front();
                if (waddr !== mon_e) begin
                    errors++;
                    $display("FAIL write_addr waddr=%0d expected %0d", waddr, mon_e);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; en = 1'b1;
        tick(); tick();
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (we !== 1'b0) begin errors++; $display("FAIL rst_we we=%0b expected 0", we); end
        end
        checks++;
        if (waddr !== 4'd0) begin errors++; $display("FAIL rst_waddr waddr=%0d expected 0", waddr); end
        checks++;
        if (armed !== 1'b0) begin errors++; $display("FAIL rst_armed armed=%0b expected 0", armed); end
        checks++;
        if (capture_done !== 1'b0) begin errors++; $display("FAIL rst_done done=%0b expected 0", capture_done); end
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy busy=%0b expected 0", busy); end
        checks++;
        if (trig_addr !== 4'd0) begin errors++; $display("FAIL rst_trig_addr trig_addr=%0d expected 0", trig_addr); end
    endtask

    task automatic test_prefill();
        en = 1'b1; trig_pos = 4'd4;
        for (int i = 0; i < 12; i++) exp_q.push_back(AW'(i));
        run = 1'b1; tick(); run = 1'b0;
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL pre_busy busy=%0b expected 1", busy); end
        for (int i = 0; i < 11; i++) tick();
        checks++;
        if (armed !== 1'b0) begin errors++; $display("FAIL pre_armed_early armed=%0b expected 0", armed); end
        tick();
        checks++;
        if (armed !== 1'b1) begin errors++; $display("FAIL pre_armed armed=%0b expected 1", armed); end
        checks++;
        if (waddr !== 4'd12) begin errors++; $display("FAIL pre_waddr waddr=%0d expected 12", waddr); end
        for (int i = 12; i < 19; i++) exp_q.push_back(AW'(i));
        for (int i = 0; i < 7; i++) tick();
        checks++;
        if (waddr !== 4'd3) begin errors++; $display("FAIL armed_wrap waddr=%0d expected 3", waddr); end
        checks++;
        if (armed !== 1'b1) begin errors++; $display("FAIL armed_hold armed=%0b expected 1", armed); end
    endtask

    task automatic test_trigger();
        for (int i = 3; i < 7; i++) exp_q.push_back(AW'(i));
        triggered = 1'b1; tick(); triggered = 1'b0;
        checks++;
        if (armed !== 1'b0) begin errors++; $display("FAIL trig_armed armed=%0b expected 0", armed); end
        checks++;
        if (trig_addr !== 4'd3) begin errors++; $display("FAIL trig_addr trig_addr=%0d expected 3", trig_addr); end
        tick(); tick();
        checks++;
        if (capture_done !== 1'b0) begin errors++; $display("FAIL post_done_early done=%0b expected 0", capture_done); end
        tick();
        checks++;
        if (capture_done !== 1'b1) begin errors++; $display("FAIL post_done done=%0b expected 1", capture_done); end
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL post_busy busy=%0b expected 0", busy); end
        checks++;
        if (we !== 1'b0) begin errors++; $display("FAIL done_we we=%0b expected 0", we); end
        tick(); tick(); tick();
        checks++;
        if (capture_done !== 1'b1) begin errors++; $display("FAIL done_hold done=%0b expected 1", capture_done); end
        clr_cap_done = 1'b1; tick(); clr_cap_done = 1'b0;
        checks++;
        if (capture_done !== 1'b0) begin errors++; $display("FAIL clr_done done=%0b expected 0", capture_done); end
    endtask

    task automatic test_early_trigger();
        en = 1'b1; trig_pos = 4'd2; triggered = 1'b1;
        for (int i = 0; i < 16; i++) exp_q.push_back(AW'(i));
        run = 1'b1; tick(); run = 1'b0;
        for (int i = 0; i < 13; i++) tick();
        checks++;
        if (armed !== 1'b0 || busy !== 1'b1) begin
            errors++; $display("FAIL early_pre armed=%0b busy=%0b expected 0 1", armed, busy);
        end
        tick();
        checks++;
        if (armed !== 1'b1) begin errors++; $display("FAIL early_armed armed=%0b expected 1", armed); end
        tick();
        checks++;
        if (trig_addr !== 4'd14) begin errors++; $display("FAIL early_trig_addr trig_addr=%0d expected 14", trig_addr); end
        triggered = 1'b0;
        tick();
        checks++;
        if (capture_done !== 1'b1) begin errors++; $display("FAIL early_done done=%0b expected 1", capture_done); end
        checks++;
        if (waddr !== 4'd0) begin errors++; $display("FAIL early_waddr waddr=%0d expected 0", waddr); end
        clr_cap_done = 1'b1; tick(); clr_cap_done = 1'b0;
    endtask

    task automatic test_tp_zero();
        en = 1'b0; trig_pos = 4'd0;
        for (int i = 0; i < 15; i++) exp_q.push_back(AW'(i));
        run = 1'b1; tick(); run = 1'b0;
        trig_pos = 4'd9;
        for (int i = 0; i < 30; i++) begin
            en = (i % 2 == 0);
            tick();
            checks++;
            if (waddr !== AW'(i / 2 + 1)) begin
                errors++; $display("FAIL tp0_waddr step=%0d waddr=%0d expected %0d", i, waddr, i / 2 + 1);
            end
        end
        checks++;
        if (armed !== 1'b1) begin errors++; $display("FAIL tp0_armed armed=%0b expected 1", armed); end
        exp_q.push_back(4'd15);
        en = 1'b1; triggered = 1'b1; tick(); triggered = 1'b0;
        checks++;
        if (capture_done !== 1'b1) begin errors++; $display("FAIL tp0_done done=%0b expected 1", capture_done); end
        checks++;
        if (trig_addr !== 4'd15) begin errors++; $display("FAIL tp0_trig_addr trig_addr=%0d expected 15", trig_addr); end
        run = 1'b1; tick(); run = 1'b0;
        checks++;
        if (capture_done !== 1'b1 || busy !== 1'b0) begin
            errors++; $display("FAIL done_run done=%0b busy=%0b expected 1 0", capture_done, busy);
        end
        run = 1'b1; clr_cap_done = 1'b1; tick(); run = 1'b0; clr_cap_done = 1'b0;
        tick();
        checks++;
        if (capture_done !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL run_clr done=%0b busy=%0b expected 0 0", capture_done, busy);
        end
    endtask

    task automatic test_abort();
        en = 1'b1; trig_pos = 4'd4;
        for (int i = 0; i < 13; i++) exp_q.push_back(AW'(i));
        run = 1'b1; tick(); run = 1'b0;
        for (int i = 0; i < 12; i++) tick();
        triggered = 1'b1; tick(); triggered = 1'b0;
        en = 1'b0; stop = 1'b1; tick(); stop = 1'b0;
        checks++;
        if (busy !== 1'b0 || armed !== 1'b0 || capture_done !== 1'b0) begin
            errors++; $display("FAIL stop_state busy=%0b armed=%0b done=%0b expected 0 0 0", busy, armed, capture_done);
        end
        checks++;
        if (waddr !== 4'd13 || trig_addr !== 4'd12) begin
            errors++; $display("FAIL stop_hold waddr=%0d trig_addr=%0d expected 13 12", waddr, trig_addr);
        end
        en = 1'b1; tick(); tick(); tick();
        for (int i = 0; i < 12; i++) exp_q.push_back(AW'(i));
        run = 1'b1; tick(); run = 1'b0;
        checks++;
        if (waddr !== 4'd0) begin errors++; $display("FAIL restart_waddr waddr=%0d expected 0", waddr); end
        for (int i = 0; i < 12; i++) tick();
        en = 1'b0; rst = 1'b1; tick(); rst = 1'b0;
        checks++;
        if (armed !== 1'b0 || busy !== 1'b0 || capture_done !== 1'b0) begin
            errors++; $display("FAIL rst_mid armed=%0b busy=%0b done=%0b expected 0 0 0", armed, busy, capture_done);
        end
        checks++;
        if (waddr !== 4'd0) begin errors++; $display("FAIL rst_mid_waddr waddr=%0d expected 0", waddr); end
        en = 1'b1; tick(); tick(); tick();
        exp_q.push_back(4'd0); exp_q.push_back(4'd1);
        run = 1'b1; tick(); run = 1'b0;
        tick(); tick();
        checks++;
        if (waddr !== 4'd2) begin errors++; $display("FAIL rerun_waddr waddr=%0d expected 2", waddr); end
        en = 1'b0; stop = 1'b1; tick(); stop = 1'b0;
    endtask

    initial begin
        rst = 1'b1; run = 1'b0; stop = 1'b0; clr_cap_done = 1'b0;
        en = 1'b0; triggered = 1'b0; trig_pos = '0;
        test_reset();
        test_prefill();
        test_trigger();
        test_early_trigger();
        test_tp_zero();
        test_abort();
        checks++;
        if (exp_q.size() != 0) begin
            errors++; $display("FAIL missing_writes pending=%0d expected 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
